// File: rtl/hc_dec_pipe.sv
// rtl/hc_dec_pipe.sv - two-stage Hamming(7,4) decoder with single-bit correction and link statistics
module hc_dec_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:1]       i_enc_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [3:0]       o_data,
    output logic [2:0]       o_syndrome,
    output logic             o_err,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [CNT_W-1:0] o_corr_cnt
);

    logic       en;
    logic       out_xfer;
    logic [2:0] syn_in;
    logic       s1_valid;
    logic [3:0] s1_data;
    logic [2:0] s1_syn;
    logic [3:0] fixed_data;

    // The whole pipe advances together; it only stalls when the output is held.
    assign en       = !o_valid | i_ready;
    assign o_ready  = en;
    assign out_xfer = o_valid & i_ready;

    assign syn_in = {i_enc_data[4] ^ i_enc_data[5] ^ i_enc_data[6] ^ i_enc_data[7],
                     i_enc_data[2] ^ i_enc_data[3] ^ i_enc_data[6] ^ i_enc_data[7],
                     i_enc_data[1] ^ i_enc_data[3] ^ i_enc_data[5] ^ i_enc_data[7]};

    // Only data positions 3,5,6,7 need correcting; parity flips just report.
    always_comb begin
        fixed_data    = s1_data;
        fixed_data[0] = s1_data[0] ^ (s1_syn == 3'd3);
        fixed_data[1] = s1_data[1] ^ (s1_syn == 3'd5);
        fixed_data[2] = s1_data[2] ^ (s1_syn == 3'd6);
        fixed_data[3] = s1_data[3] ^ (s1_syn == 3'd7);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_syn     <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_syndrome <= '0;
            o_err      <= 1'b0;
        end else if (en) begin
            s1_valid   <= i_valid;
            s1_data    <= {i_enc_data[7], i_enc_data[6], i_enc_data[5], i_enc_data[3]};
            s1_syn     <= syn_in;
            o_valid    <= s1_valid;
            o_data     <= fixed_data;
            o_syndrome <= s1_syn;
            o_err      <= (s1_syn != 3'd0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            o_word_cnt <= '0;
            o_corr_cnt <= '0;
        end else if (out_xfer) begin
            if (o_word_cnt != {CNT_W{1'b1}})
                o_word_cnt <= o_word_cnt + CNT_W'(1);
            if (o_err && (o_corr_cnt != {CNT_W{1'b1}}))
                o_corr_cnt <= o_corr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hc_dec_pipe.md
Name: hc_dec_pipe

Overview:
Pipelined Hamming(7,4) decoder. It is the receive-side counterpart of the team's hc_enc encoder. It accepts 7-bit codewords on a valid/ready stream, computes the syndrome, corrects any single-bit error, and emits the 4-bit data word with error status. Saturating statistics counters track total words and corrected words, for link-health monitoring.

Parameters:
CNT_W, 16, width of the statistics counters o_word_cnt and o_corr_cnt.

Ports:
i_clk  input  1  sole clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  upstream codeword valid
o_ready  output  1  decoder can accept a codeword this cycle
i_enc_data  input  7 [7:1]  codeword; bit index = Hamming position
o_valid  output  1  decoded word valid
i_ready  input  1  downstream accepts the decoded word
o_data  output  4 [3:0]  corrected data
o_syndrome  output  3 [2:0]  {s4,s2,s1}; nonzero = position of the flipped bit
o_err  output  1  syndrome nonzero (a correction was applied)
i_cnt_clr  input  1  synchronous clear of both counters
o_word_cnt  output  CNT_W  words delivered (output handshakes)
o_corr_cnt  output  CNT_W  delivered words that had o_err=1

Behaviour:
- Interface: one clock (i_clk). Reset (i_rst) is synchronous and active-high.
- Codeword map (must match hc_enc):
  - d0 at position 3, d1 at 5, d2 at 6, d3 at 7.
  - p1 at position 1 = d0^d1^d3.
  - p2 at position 2 = d0^d2^d3.
  - p4 at position 4 = d1^d2^d3.
- Syndrome:
  - s1 = c1^c3^c5^c7.
  - s2 = c2^c3^c6^c7.
  - s4 = c4^c5^c6^c7.
- Pipeline, 2 stages:
  - Stage 1 registers the codeword, syndrome and a valid bit.
  - Stage 2 flips the bit at position = syndrome (none if 0), then registers o_data, o_syndrome, o_err and o_valid.
- Latency is 2 cycles from input handshake to o_valid when there is no backpressure. Throughput is 1 word/cycle.
- Handshake:
  - en = !o_valid | i_ready, and o_ready = en.
  - Input transfer occurs on i_valid & o_ready. Output transfer occurs on o_valid & i_ready.
  - When en=0, all pipeline registers hold. o_data, o_syndrome and o_err stay stable while o_valid=1 and i_ready=0.
  - When en=1 and i_valid=0, a bubble (valid=0) enters stage 1.
- Flips of a parity bit (syndrome 1, 2 or 4) set o_err=1 and leave o_data equal to the unchanged data bits.
- Double-bit errors are not detected. They miscorrect silently, and this is accepted behaviour.
- Counters:
  - On each output transfer, o_word_cnt increments.
  - If that transfer has o_err=1, o_corr_cnt also increments.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - When i_cnt_clr and an increment occur in the same cycle, clear wins and the counter is 0 next cycle.
  - i_cnt_clr does not affect the pipeline.
- Reset values:
  - o_valid=0, o_data=0, o_syndrome=0, o_err=0.
  - o_word_cnt=0, o_corr_cnt=0.
  - Stage-1 valid=0.
  - o_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: all in-flight words are discarded. No output handshake occurs in the reset cycle, and counters are zeroed.
- Upstream must hold i_enc_data stable while i_valid=1 and o_ready=0. Downstream may drop i_ready at any time.

Test Plan:
- Clean stream: send the hc_enc outputs for data 0000, 0001, 0010, 0100, 1000, 1111, 1010, 0110 back-to-back with i_ready=1 -> o_data matches each input exactly 2 cycles after its handshake. Every o_err=0 and o_syndrome=000. o_word_cnt=8 and o_corr_cnt=0.
- Single data-bit error: codeword 7'b1010101 (data 1011) sent as 7'b1110101 (bit 6 flipped) -> o_data=1011, o_syndrome=110, o_err=1, o_corr_cnt increments by 1.
- Parity-bit error: 7'b0000000 sent as 7'b0000001 -> o_data=0000, o_syndrome=001, o_err=1. Sweep a single flip at each position 1..7 for data 1011 -> o_syndrome equals the flipped position and o_data=1011 every time.
- Backpressure: stream 4 words and hold i_ready=0 for 5 cycles after the first o_valid -> o_ready=0 while both stages are full. Outputs stay stable during the stall. No word is lost or duplicated, order is preserved, and o_word_cnt=4 at the end.
- Counter saturation/clear with CNT_W=2: deliver 5 erroneous words -> both counters stop at 3. Assert i_cnt_clr on the cycle of a 6th transfer -> both counters read 0 on the next cycle.
- Reset mid-stream: assert i_rst for 1 cycle with both stages valid -> next cycle o_valid=0 and counters are 0. A new word sent afterwards decodes correctly with 2-cycle latency.
